// File: rtl/onehot_encoder_serial_pkg.sv
// Shared types and helpers for the serializing 8-to-3 encoder.
// Holds the FSM state enum and lowest-set-bit helper functions.
package onehot_enc_pkg;

  localparam int ENC_W    = 8;
  localparam int ENC_IDXW = $clog2(ENC_W);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  function automatic logic [ENC_IDXW-1:0] lsb_index(
    input logic [ENC_W-1:0] vec
  );
    logic [ENC_IDXW-1:0] idx;
    idx = '0;
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = ENC_IDXW'(i);
    end
    return idx;
  endfunction

  function automatic logic at_most_one(
    input logic [ENC_W-1:0] vec
  );
    return (vec & (vec - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/onehot_encoder_serial_if.sv
// Request-vector and index-beat handshakes of the serial encoder.
// slave is the encoder's view, master the producer/consumer view.
interface onehot_encoder_serial_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out;
  logic             out_last;
  logic             out_zero;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in,
    output out_valid,
    input  out_ready,
    output out,
    output out_last,
    output out_zero
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in,
    input  out_valid,
    output out_ready,
    input  out,
    input  out_last,
    input  out_zero
  );

endinterface

// File: rtl/onehot_encoder_serial_lsb_prio_enc.sv
// Combinational priority encoder: index of the lowest set bit.
// any_set flags a non-zero input; idx is 0 when nothing is set.
module lsb_prio_enc #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any_set
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/onehot_encoder_serial.sv
// Serializing 8-to-3 encoder: one index beat per set bit, LSB first.
// A zero vector yields a single beat flagged out_zero.
module onehot_encoder_serial
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = ENC_W,
  localparam int IDXW = $clog2(WIDTH)
) (
  input logic                     clk,
  input logic                     rst_n,
  onehot_encoder_serial_if.slave  bus
);

  enc_state_e       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;

  logic [IDXW-1:0]  lsb_idx;
  logic             lsb_any;
  logic             beat;
  logic             last_beat;
  logic             accept;
  logic             emit;

  lsb_prio_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .vec    (pending_q),
    .idx    (lsb_idx),
    .any_set(lsb_any)
  );

  // output decode and handshake qualifiers
  always_comb begin
    emit          = (state_q == EMIT);
    bus.out_valid = emit;
    bus.out       = '0;
    bus.out_last  = 1'b0;
    bus.out_zero  = 1'b0;
    if (emit) begin
      bus.out      = (zero_q || !lsb_any) ? '0 : lsb_idx;
      bus.out_last = at_most_one(pending_q);
      bus.out_zero = zero_q;
    end
    beat         = emit && bus.out_ready;
    last_beat    = beat && bus.out_last;
    bus.in_ready = !emit || last_beat;
    accept       = bus.in_valid && bus.in_ready;
  end

  // next state: retire a bit per beat, reload on acceptance
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    if (beat) begin
      pending_d = pending_q & (pending_q - 1'b1);
    end
    if (accept) begin
      pending_d = bus.in;
      zero_d    = (bus.in == '0);
      state_d   = EMIT;
    end else if (last_beat) begin
      state_d   = IDLE;
    end
  end

  // state and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_serial.sv
// Self-checking bench for the serializing 8-to-3 encoder.
// Table of vectors plus directed multi-cycle sequences.
module tb_onehot_encoder_serial;

  typedef struct {
    logic [7:0]      vec;
    int              n;
    logic            zero;
    logic [7:0][2:0] idx;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  onehot_encoder_serial_if #(.WIDTH(8)) bus ();

  onehot_encoder_serial dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] v, input int n,
                              input logic z,
                              input int b0 = 0, input int b1 = 0,
                              input int b2 = 0, input int b3 = 0,
                              input int b4 = 0, input int b5 = 0,
                              input int b6 = 0, input int b7 = 0);
    vec_t r;
    r.vec    = v;
    r.n      = n;
    r.zero   = z;
    r.idx[0] = 3'(b0);
    r.idx[1] = 3'(b1);
    r.idx[2] = 3'(b2);
    r.idx[3] = 3'(b3);
    r.idx[4] = 3'(b4);
    r.idx[5] = 3'(b5);
    r.idx[6] = 3'(b6);
    r.idx[7] = 3'(b7);
    return r;
  endfunction

  // accept one vector from IDLE; returns at the negedge of beat 0
  task automatic send(input logic [7:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in       = v;
    #1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    chk("no_valid_idle", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in       = 8'h00;
  endtask

  vec_t tbl [7];

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in        = 8'hFF;
    bus.out_ready = 1'b1;

    tbl[0] = mk(8'b1010_0100, 3, 1'b0, 2, 5, 7);
    tbl[1] = mk(8'h00, 1, 1'b1, 0);
    tbl[2] = mk(8'h01, 1, 1'b0, 0);
    tbl[3] = mk(8'h80, 1, 1'b0, 7);
    tbl[4] = mk(8'h81, 2, 1'b0, 0, 7);
    tbl[5] = mk(8'h18, 2, 1'b0, 3, 4);
    tbl[6] = mk(8'hFF, 8, 1'b0, 0, 1, 2, 3, 4, 5, 6, 7);

    // reset held with a valid request pending
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end

    // table: each vector drained with out_ready high
    foreach (tbl[t]) begin
      send(tbl[t].vec);
      for (int k = 0; k < tbl[t].n; k++) begin
        chk("tbl_valid", 32'(bus.out_valid), 32'd1);
        chk("tbl_out", 32'(bus.out), 32'(tbl[t].idx[k]));
        chk("tbl_last", 32'(bus.out_last),
            32'(k == tbl[t].n - 1));
        chk("tbl_zero", 32'(bus.out_zero), 32'(tbl[t].zero));
        @(negedge clk);
      end
      chk("tbl_done", 32'(bus.out_valid), 32'd0);
    end

    // backpressure: stall three cycles on out=3
    send(8'hFF);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 8'h55;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_out", 32'(bus.out), 32'd3);
          chk("stall_last", 32'(bus.out_last), 32'd0);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out", 32'(bus.out), 32'(k));
      chk("bp_last", 32'(bus.out_last), 32'(k == 7));
      @(negedge clk);
    end
    chk("bp_done", 32'(bus.out_valid), 32'd0);

    // back-to-back: 0x01 accepted on the last beat of 0x80
    send(8'h80);
    chk("b2b_first", 32'(bus.out), 32'd7);
    chk("b2b_first_last", 32'(bus.out_last), 32'd1);
    bus.in_valid = 1'b1;
    bus.in       = 8'h01;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    #1;
    chk("b2b_ready_comb", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in       = 8'h00;
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_second", 32'(bus.out), 32'd0);
    chk("b2b_second_last", 32'(bus.out_last), 32'd1);
    @(negedge clk);
    chk("b2b_done", 32'(bus.out_valid), 32'd0);

    // reset right after beat out=4 is accepted
    send(8'hF0);
    chk("mid_beat4", 32'(bus.out), 32'd4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
